// File: rtl/bram_stream_reader_if.sv
// Bundle of signals between bram_stream_reader and its surroundings.
// The RAM port and the output stream sit in one bundle because the reader is
// always wired straight between a single-port RAM and one stream consumer.
//   start/base_addr/length  : transfer request, sampled while idle
//   busy/done               : transfer status
//   ram_enable/write_enable/address, ram_data : RAM read port
//   out_data/out_valid/out_last, out_ready    : valid/ready output stream
// Modports: slave = the reader itself, master = the environment that
// requests transfers, models the RAM and consumes the stream.
interface bram_stream_reader_if #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 8
);
  logic                     start;
  logic [RAM_ADDR_BITS-1:0] base_addr;
  logic [RAM_ADDR_BITS:0]   length;
  logic                     busy;
  logic                     done;
  logic                     ram_enable;
  logic                     write_enable;
  logic [RAM_ADDR_BITS-1:0] address;
  logic [RAM_WIDTH-1:0]     ram_data;
  logic [RAM_WIDTH-1:0]     out_data;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;

  modport slave (
    input  start, base_addr, length, ram_data, out_ready,
    output busy, done, ram_enable, write_enable, address, out_data, out_valid, out_last
  );

  modport master (
    output start, base_addr, length, ram_data, out_ready,
    input  busy, done, ram_enable, write_enable, address, out_data, out_valid, out_last
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Read sequencer for a single-port block RAM with a 1-cycle registered output.
// Reads `length` words from a wrapping address range starting at `base_addr`
// and presents them as a valid/ready stream with a last marker.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : request/status, RAM read port and output stream (slave modport)
// A 2-entry buffer absorbs the RAM latency: a read is only issued when the
// buffer has room for it once every outstanding word has landed, so a full
// rate consumer gets one word per cycle and backpressure never drops data.
module bram_stream_reader #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  bram_stream_reader_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  localparam logic [RAM_ADDR_BITS:0] RemOne = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

  state_e                   state_q;
  logic [RAM_ADDR_BITS-1:0] next_addr_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [RAM_ADDR_BITS:0]   remaining_q;
  logic                     inflight_q;
  logic                     inflight_last_q;
  logic                     busy_q;
  logic                     done_q;
  logic [RAM_WIDTH-1:0]     buf_data_q [2];
  logic [1:0]               buf_last_q;
  logic                     rd_ptr_q;
  logic                     wr_ptr_q;
  logic [1:0]               count_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] credit_used;

  always_comb begin
    pop         = (count_q != 2'd0) && bus.out_ready;
    push        = inflight_q;
    // Slots the buffer would hold after this edge if nothing new were issued.
    credit_used = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue       = (state_q == StRead) && (remaining_q != '0) && (credit_used < 3'd2);
  end

  assign bus.ram_enable   = issue;
  assign bus.write_enable = 1'b0;
  // Hold the last issued address while the RAM is not enabled.
  assign bus.address      = issue ? next_addr_q : addr_q;
  assign bus.out_valid    = (count_q != 2'd0);
  assign bus.out_data     = buf_data_q[rd_ptr_q];
  assign bus.out_last     = (count_q != 2'd0) && buf_last_q[rd_ptr_q];
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      next_addr_q     <= '0;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      buf_data_q[0]   <= '0;
      buf_data_q[1]   <= '0;
      buf_last_q      <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      if (issue) begin
        addr_q          <= next_addr_q;
        next_addr_q     <= next_addr_q + 1'b1;
        remaining_q     <= remaining_q - 1'b1;
        inflight_last_q <= (remaining_q == RemOne);
      end
      inflight_q <= issue;

      // RAM output is valid exactly in the cycle after an issue.
      if (push) begin
        buf_data_q[wr_ptr_q] <= bus.ram_data;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};

      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            next_addr_q <= bus.base_addr;
            remaining_q <= bus.length;
            busy_q      <= 1'b1;
            if (bus.length == '0) begin
              state_q <= StFin;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          if (issue && (remaining_q == RemOne)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Finish once nothing is in flight and this cycle empties the buffer.
          if (!inflight_q && (count_q == {1'b0, pop})) begin
            state_q <= StFin;
            done_q  <= 1'b1;
          end
        end
        StFin: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
